// File: rtl/spixel_draw_sched.sv
// spixel_draw_sched: queue head/tail/apple/clear draw requests and issue them one at a time to draw_superpixel
module spixel_draw_sched #(
    parameter int H_LOGIC_WIDTH = 5,
    parameter int V_LOGIC_WIDTH = 5,
    parameter int H_LOGIC_MAX = 31,
    parameter int V_LOGIC_MAX = 23,
    parameter int COLOR_ID_WIDTH = 8,
    parameter logic [COLOR_ID_WIDTH-1:0] BG_COLOR = 8'h0f,
    parameter logic [COLOR_ID_WIDTH-1:0] APPLE_COLOR = 8'hf9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic head_vld,
    input  logic [H_LOGIC_WIDTH-1:0] head_x,
    input  logic [V_LOGIC_WIDTH-1:0] head_y,
    input  logic [COLOR_ID_WIDTH-1:0] head_color,
    input  logic tail_vld,
    input  logic [H_LOGIC_WIDTH-1:0] tail_x,
    input  logic [V_LOGIC_WIDTH-1:0] tail_y,
    input  logic apple_vld,
    input  logic [H_LOGIC_WIDTH-1:0] apple_x,
    input  logic [V_LOGIC_WIDTH-1:0] apple_y,
    input  logic clr_start,
    input  logic idone,
    output logic [H_LOGIC_WIDTH-1:0] ox,
    output logic [V_LOGIC_WIDTH-1:0] oy,
    output logic [COLOR_ID_WIDTH-1:0] odata,
    output logic odata_vld,
    output logic busy,
    output logic clr_done,
    output logic [2:0] ovf
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CLR_ISSUE, CLR_WAIT} state_t;
    state_t state, state_d;
    logic hp, tp, ap, cp;
    logic [H_LOGIC_WIDTH-1:0] hx, tx, ax, cx, cx_n;
    logic [V_LOGIC_WIDTH-1:0] hy, ty, ay, cy, cy_n;
    logic [COLOR_ID_WIDTH-1:0] hc;
    logic take_h, take_t, take_a, clr_go, clr_adv, clr_fin, cx_last, cy_last;

    assign cx_last = cx == H_LOGIC_WIDTH'(H_LOGIC_MAX);
    assign cy_last = cy == V_LOGIC_WIDTH'(V_LOGIC_MAX);
    assign cx_n = cx_last ? '0 : cx + 1'b1;
    assign cy_n = cx_last ? cy + 1'b1 : cy;
    assign odata_vld = state == ISSUE || state == CLR_ISSUE;
    assign busy = state != IDLE || hp || tp || ap || cp;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    // next state and slot selection; clear outranks tail, head, apple
    always_comb begin
        state_d = state;
        take_h = 1'b0;
        take_t = 1'b0;
        take_a = 1'b0;
        clr_go = 1'b0;
        clr_adv = 1'b0;
        clr_fin = 1'b0;
        case (state)
            IDLE: begin
                clr_go = cp;
                take_t = !cp && tp;
                take_h = !cp && !tp && hp;
                take_a = !cp && !tp && !hp && ap;
                state_d = cp ? CLR_ISSUE : (tp || hp || ap) ? ISSUE : IDLE;
            end
            ISSUE: state_d = WAIT;
            WAIT: state_d = idone ? IDLE : WAIT;
            CLR_ISSUE: state_d = CLR_WAIT;
            CLR_WAIT: begin
                clr_fin = idone && cx_last && cy_last;
                clr_adv = idone && !(cx_last && cy_last);
                state_d = clr_fin ? IDLE : clr_adv ? CLR_ISSUE : CLR_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // pending slots; a capture wins over a same-edge consume and only flags a true overwrite
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {hp, tp, ap, cp} <= '0;
            {hx, hy, hc, tx, ty, ax, ay} <= '0;
            ovf <= '0;
        end else begin
            if (head_vld) {hp, hx, hy, hc} <= {1'b1, head_x, head_y, head_color};
            else if (take_h) hp <= 1'b0;
            if (tail_vld) {tp, tx, ty} <= {1'b1, tail_x, tail_y};
            else if (take_t) tp <= 1'b0;
            if (apple_vld) {ap, ax, ay} <= {1'b1, apple_x, apple_y};
            else if (take_a) ap <= 1'b0;
            if (clr_start && !cp) cp <= 1'b1;
            else if (clr_fin) cp <= 1'b0;
            ovf <= ovf | {apple_vld && ap && !take_a, tail_vld && tp && !take_t, head_vld && hp && !take_h};
        end
    end

    // draw outputs and clear sweep counters, which ox/oy mirror during a clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {ox, oy, odata, cx, cy} <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= clr_fin;
            if (take_t) {ox, oy, odata} <= {tx, ty, BG_COLOR};
            else if (take_h) {ox, oy, odata} <= {hx, hy, hc};
            else if (take_a) {ox, oy, odata} <= {ax, ay, APPLE_COLOR};
            else if (clr_go) {ox, oy, odata, cx, cy} <= {{(H_LOGIC_WIDTH+V_LOGIC_WIDTH){1'b0}}, BG_COLOR, {(H_LOGIC_WIDTH+V_LOGIC_WIDTH){1'b0}}};
            else if (clr_adv) {ox, oy, cx, cy} <= {cx_n, cy_n, cx_n, cy_n};
        end
    end
endmodule
